uart_seq_checker: RTL and testbench
===================================

Name: uart_seq_checker

Overview:
Receiver-end companion of the main board's UART test/command stream. It sits in FPGA_modulo behind uart_rx and in front of uart_tx. It checks that incoming bytes form a wrapping incrementing sequence (0x00, 0x01, ... 0xFF, 0x00 ...), counts sequence and parity errors, and reports lock status. Every ACK_EVERY good bytes it returns an ACK byte (0x3C) to the main board through the uart_tx start/busy handshake.

Parameters:
ACK_EVERY, 256, number of in-sequence bytes between ACK transmissions (>=1)
LOCK_GOOD, 4, consecutive in-sequence bytes needed to assert locked
LOCK_LOSS, 3, consecutive errors (sequence or parity) that drop lock and return to SYNC
ERR_WIDTH, 16, width of the error counters (saturating)
TX_TIMEOUT, 4800, cycles to wait for tx_busy to rise after start_tx before abandoning the ACK

Ports:
clk  in  1  system clock (48 MHz SB_HFOSC)
reset  in  1  asynchronous, active-high reset
rx_data  in  8  byte from uart_rx, valid when rx_done=1
rx_done  in  1  single-cycle strobe from uart_rx
rx_parity_error  in  1  parity flag from uart_rx, valid with rx_done
tx_busy  in  1  busy flag from uart_tx
clear_counts  in  1  synchronous clear of all counters and sticky flags
tx_data  out  8  byte to uart_tx
start_tx  out  1  start request to uart_tx
locked  out  1  sequence lock indicator
byte_count  out  32  total rx_done strobes accepted (wraps)
seq_err_count  out  ERR_WIDTH  sequence mismatches (saturates at all-ones)
par_err_count  out  ERR_WIDTH  parity-flagged bytes (saturates)
tx_timeout  out  1  sticky: an ACK was abandoned because tx_busy never rose

Behaviour:
- Reset values: tx_data=0x3C, start_tx=0, locked=0, all counters=0, tx_timeout=0, expected=0, rx FSM=SYNC, tx FSM=IDLE.
- Every rx_done strobe increments byte_count by 1, in every state.
- rx FSM states: SYNC, TRACK.
- SYNC: first byte with rx_parity_error=0 sets expected=rx_data+1 (mod 256), good_run=1, then goes to TRACK. Parity-flagged bytes in SYNC increment par_err_count only.
- TRACK, good byte (rx_parity_error=0 and rx_data==expected):
  - expected+=1 (0xFF wraps to 0x00); good_run+=1 (saturating); err_run=0; ack_cnt+=1.
  - When ack_cnt reaches ACK_EVERY: ack_cnt=0 and ack_pend=1.
- TRACK, mismatch: seq_err_count+=1; expected=rx_data+1 (resync); good_run=0; err_run+=1.
- TRACK, parity error: par_err_count+=1; expected+=1 (the byte is treated as lost); good_run=0; err_run+=1.
- When err_run reaches LOCK_LOSS: go to SYNC, locked=0, ack_cnt=0, err_run=0.
- locked=1 registered on the cycle after good_run reaches LOCK_GOOD; locked=0 on entry to SYNC.
- tx FSM states: IDLE, REQ, BUSY.
  - IDLE: if ack_pend and tx_busy=0, set start_tx=1, clear ack_pend, go to REQ.
  - REQ: hold start_tx=1 until tx_busy=1, then start_tx=0 and go to BUSY. If TX_TIMEOUT cycles pass first, start_tx=0, tx_timeout=1, go to IDLE.
  - BUSY: wait for tx_busy=0, then go to IDLE.
- ACK requested while the tx FSM is not in IDLE stays pending as a single flag. Further requests are not queued; they merge into the one pending ACK.
- rx_done and the ACK handshake proceed independently in the same cycle.
- clear_counts: zeroes all counters and tx_timeout. It does not change FSM states, expected, or locked. If clear_counts and rx_done occur in the same cycle, the clear wins and the byte is not counted.
- Asynchronous reset mid-transmission drops start_tx immediately. uart_tx's own reset handles the line.

Decomposition:
- UART.vh gains ACK_BYTE (8'h3C) and the rx/tx FSM state encodings.
- One natural sub-module, uart_ack_tx: the IDLE/REQ/BUSY handshake plus timeout. It is reusable by any block that sends single bytes through uart_tx.

Test Plan:
- Bytes 0x00..0x07 fed cleanly -> locked=1 after the 4th byte (+1 cycle), seq_err_count=0, byte_count=8.
- Sequence 0xFD,0xFE,0xFF,0x00,0x01 -> no errors; the wrap is accepted.
- While locked, feed 0x10,0x11,0x20,0x21 -> seq_err_count=1, no further errors after the resync, locked stays 1.
- ACK_EVERY=4 with 9 good bytes and the tx_busy model responding 2 cycles after start -> exactly 2 ACKs, tx_data=0x3C, start_tx drops on the cycle after tx_busy rises.
- Three consecutive parity-flagged bytes while locked -> par_err_count=3, locked=0, FSM back in SYNC; the next clean byte restarts tracking.
- ACK pending with tx_busy held low forever, TX_TIMEOUT=16 -> start_tx high for 16 cycles then low, tx_timeout=1; clear_counts clears tx_timeout.

Source files
------------

// File: rtl/uart_seq_checker_pkg.sv
// Shared constants and state encodings for the UART sequence checker
// and its single-byte ACK transmitter.
package uart_seq_checker_pkg;

    localparam logic [7:0] ACK_BYTE = 8'h3C;

    typedef enum logic {
        RX_SYNC  = 1'b0,
        RX_TRACK = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_seq_checker_ack_tx.sv
// Single-byte sender for uart_tx: start/busy handshake with a start-to-busy
// timeout. Requests arriving while a send is pending or in flight merge.
module uart_ack_tx
    import uart_seq_checker_pkg::*;
#(
    parameter int TX_TIMEOUT = 4800
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    input  logic       i_clear_timeout,
    output logic [7:0] o_tx_data,
    output logic       o_start_tx,
    output logic       o_timeout
);

    localparam int            TW     = $clog2(TX_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TX_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE = TW'(1);

    tx_state_t     r_state;
    logic          r_pend;
    logic [TW-1:0] r_to_cnt;
    logic          w_take;

    assign w_take = (r_state == TX_IDLE) && r_pend && !i_tx_busy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= TX_IDLE;
            r_pend     <= 1'b0;
            r_to_cnt   <= '0;
            o_tx_data  <= ACK_BYTE;
            o_start_tx <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            // A request landing on the cycle the previous one is taken stays pending.
            r_pend <= i_req | (r_pend & ~w_take);

            case (r_state)
                TX_IDLE: begin
                    if (w_take) begin
                        o_tx_data  <= i_byte;
                        o_start_tx <= 1'b1;
                        r_to_cnt   <= '0;
                        r_state    <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (i_tx_busy) begin
                        o_start_tx <= 1'b0;
                        r_state    <= TX_BUSY;
                    end else if (r_to_cnt == TO_LIM) begin
                        o_start_tx <= 1'b0;
                        o_timeout  <= 1'b1;
                        r_state    <= TX_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_ONE;
                    end
                end
                TX_BUSY: begin
                    if (!i_tx_busy) r_state <= TX_IDLE;
                end
                default: begin
                    o_start_tx <= 1'b0;
                    r_state    <= TX_IDLE;
                end
            endcase

            if (i_clear_timeout) o_timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_seq_checker.sv
// Checks that received bytes form a wrapping incrementing sequence, tracks
// lock, counts sequence/parity errors and sends an ACK every ACK_EVERY good bytes.
module uart_seq_checker
    import uart_seq_checker_pkg::*;
#(
    parameter int ACK_EVERY  = 256,
    parameter int LOCK_GOOD  = 4,
    parameter int LOCK_LOSS  = 3,
    parameter int ERR_WIDTH  = 16,
    parameter int TX_TIMEOUT = 4800
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_rx_parity_error,
    input  logic                 i_tx_busy,
    input  logic                 i_clear_counts,
    output logic [7:0]           o_tx_data,
    output logic                 o_start_tx,
    output logic                 o_locked,
    output logic [31:0]          o_byte_count,
    output logic [ERR_WIDTH-1:0] o_seq_err_count,
    output logic [ERR_WIDTH-1:0] o_par_err_count,
    output logic                 o_tx_timeout
);

    localparam int            GW        = $clog2(LOCK_GOOD + 1);
    localparam int            EW        = $clog2(LOCK_LOSS + 1);
    localparam int            AW        = $clog2(ACK_EVERY + 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_GOOD);
    localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
    localparam logic [EW-1:0] LOSS_LIM  = EW'(LOCK_LOSS);
    localparam logic [EW-1:0] ERR_ONE   = EW'(1);
    localparam logic [AW-1:0] ACK_LIM   = AW'(ACK_EVERY);
    localparam logic [AW-1:0] ACK_ONE   = AW'(1);
    localparam logic [ERR_WIDTH-1:0] CNT_ONE = ERR_WIDTH'(1);

    rx_state_t            r_state;
    logic [7:0]           r_expected;
    logic [GW-1:0]        r_good_run;
    logic [EW-1:0]        r_err_run;
    logic [AW-1:0]        r_ack_cnt;
    logic                 r_ack_req;
    logic                 r_locked;
    logic [31:0]          r_byte_count;
    logic [ERR_WIDTH-1:0] r_seq_err;
    logic [ERR_WIDTH-1:0] r_par_err;

    logic                 w_match;
    logic                 w_mismatch;
    logic [EW-1:0]        w_err_next;
    logic [AW-1:0]        w_ack_next;

    always_comb begin
        w_match    = !i_rx_parity_error && (i_rx_data == r_expected);
        w_mismatch = i_rx_done && (r_state == RX_TRACK) && !i_rx_parity_error &&
                     (i_rx_data != r_expected);
        w_err_next = r_err_run + ERR_ONE;
        w_ack_next = r_ack_cnt + ACK_ONE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= RX_SYNC;
            r_expected <= 8'h00;
            r_good_run <= '0;
            r_err_run  <= '0;
            r_ack_cnt  <= '0;
            r_ack_req  <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_ack_req <= 1'b0;
            // Lock follows the run one cycle later; the SYNC-entry clear below wins.
            if (r_state == RX_TRACK && r_good_run == GOOD_MAX) r_locked <= 1'b1;

            if (i_rx_done) begin
                if (r_state == RX_SYNC) begin
                    if (!i_rx_parity_error) begin
                        r_expected <= i_rx_data + 8'd1;
                        r_good_run <= GOOD_ONE;
                        r_err_run  <= '0;
                        r_state    <= RX_TRACK;
                    end
                end else if (w_match) begin
                    r_expected <= r_expected + 8'd1;
                    if (r_good_run != GOOD_MAX) r_good_run <= r_good_run + GOOD_ONE;
                    r_err_run <= '0;
                    if (w_ack_next == ACK_LIM) begin
                        r_ack_cnt <= '0;
                        r_ack_req <= 1'b1;
                    end else begin
                        r_ack_cnt <= w_ack_next;
                    end
                end else begin
                    // Parity-flagged byte is treated as lost; a wrong value resyncs to it.
                    r_expected <= i_rx_parity_error ? r_expected + 8'd1 : i_rx_data + 8'd1;
                    r_good_run <= '0;
                    if (w_err_next == LOSS_LIM) begin
                        r_state   <= RX_SYNC;
                        r_locked  <= 1'b0;
                        r_ack_cnt <= '0;
                        r_err_run <= '0;
                    end else begin
                        r_err_run <= w_err_next;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_byte_count <= 32'd0;
            r_seq_err    <= '0;
            r_par_err    <= '0;
        end else if (i_clear_counts) begin
            r_byte_count <= 32'd0;
            r_seq_err    <= '0;
            r_par_err    <= '0;
        end else if (i_rx_done) begin
            r_byte_count <= r_byte_count + 32'd1;
            if (i_rx_parity_error && r_par_err != '1) r_par_err <= r_par_err + CNT_ONE;
            if (w_mismatch && r_seq_err != '1) r_seq_err <= r_seq_err + CNT_ONE;
        end
    end

    uart_ack_tx #(
        .TX_TIMEOUT (TX_TIMEOUT)
    ) u_ack_tx (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_req           (r_ack_req),
        .i_byte          (ACK_BYTE),
        .i_tx_busy       (i_tx_busy),
        .i_clear_timeout (i_clear_counts),
        .o_tx_data       (o_tx_data),
        .o_start_tx      (o_start_tx),
        .o_timeout       (o_tx_timeout)
    );

    assign o_locked        = r_locked;
    assign o_byte_count    = r_byte_count;
    assign o_seq_err_count = r_seq_err;
    assign o_par_err_count = r_par_err;

endmodule

// File: tb/tb_uart_seq_checker.sv
// Bench for uart_seq_checker: byte vector table with hand-derived expected
// counters/lock, ACK scoreboard, and hand sequences for clear/reset/timeout.
module tb_uart_seq_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        rx_parity_error = 1'b0;
    logic        tx_busy = 1'b0;
    logic        clear_counts = 1'b0;
    logic [7:0]  tx_data;
    logic        start_tx;
    logic        locked;
    logic [31:0] byte_count;
    logic [15:0] seq_err_count;
    logic [15:0] par_err_count;
    logic        tx_timeout;

    always #5 clk = ~clk;

    uart_seq_checker #(
        .ACK_EVERY(4), .LOCK_GOOD(4), .LOCK_LOSS(3), .ERR_WIDTH(16), .TX_TIMEOUT(16)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_rx_parity_error(rx_parity_error), .i_tx_busy(tx_busy),
        .i_clear_counts(clear_counts), .o_tx_data(tx_data), .o_start_tx(start_tx),
        .o_locked(locked), .o_byte_count(byte_count), .o_seq_err_count(seq_err_count),
        .o_par_err_count(par_err_count), .o_tx_timeout(tx_timeout)
    );

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       l;
        int         seq;
        int         par;
        int         bc;
        logic       ack;
    } vec_t;

    vec_t       vecs[38];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] ack_q[$];
    logic [7:0] ack_exp;
    logic       resp_en = 1'b0;
    logic       prev_start = 1'b0;

    function automatic vec_t mk(input logic [7:0] d, input logic p, input logic l,
                                input int seq, input int par, input int bc, input logic ack);
        vec_t v;
        v.d = d; v.p = p; v.l = l; v.seq = seq; v.par = par; v.bc = bc; v.ack = ack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic p);
        @(negedge clk);
        rx_data = d; rx_parity_error = p; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; rx_parity_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_start();
        int n = 0;
        while (start_tx !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_rise", {31'd0, start_tx}, 32'd1);
    endtask

    // Scoreboard: each rising start_tx consumes one expected ACK byte.
    always @(negedge clk) begin
        if (start_tx === 1'b1 && prev_start === 1'b0) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got start_tx with tx_data %0h, expected none", tx_data);
            end else begin
                ack_exp = ack_q.pop_front();
                chk("ack_data", {24'd0, tx_data}, {24'd0, ack_exp});
            end
        end
        prev_start = start_tx;
    end

    // uart_tx model: busy rises two cycles after start is seen, lasts two cycles.
    always @(negedge clk) begin
        if (resp_en && start_tx === 1'b1 && !tx_busy) begin
            @(negedge clk);
            @(negedge clk);
            chk("start_hold", {31'd0, start_tx}, 32'd1);
            tx_busy = 1'b1;
            @(negedge clk);
            chk("start_drop", {31'd0, start_tx}, 32'd0);
            @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //            data  p  L  seq par bc ack
        vecs[0]  = mk(8'h00, 0, 0, 0, 0, 1,  0);
        vecs[1]  = mk(8'h01, 0, 0, 0, 0, 2,  0);
        vecs[2]  = mk(8'h02, 0, 0, 0, 0, 3,  0);
        vecs[3]  = mk(8'h03, 0, 1, 0, 0, 4,  0);
        vecs[4]  = mk(8'h04, 0, 1, 0, 0, 5,  1);
        vecs[5]  = mk(8'h05, 0, 1, 0, 0, 6,  0);
        vecs[6]  = mk(8'h06, 0, 1, 0, 0, 7,  0);
        vecs[7]  = mk(8'h07, 0, 1, 0, 0, 8,  0);
        vecs[8]  = mk(8'h08, 0, 1, 0, 0, 9,  1);
        vecs[9]  = mk(8'h09, 0, 1, 0, 0, 10, 0);
        vecs[10] = mk(8'h0A, 0, 1, 0, 0, 11, 0);
        vecs[11] = mk(8'h0B, 0, 1, 0, 0, 12, 0);
        vecs[12] = mk(8'h0C, 0, 1, 0, 0, 13, 1);
        vecs[13] = mk(8'h0D, 0, 1, 0, 0, 14, 0);
        vecs[14] = mk(8'h0E, 0, 1, 0, 0, 15, 0);
        vecs[15] = mk(8'h0F, 0, 1, 0, 0, 16, 0);
        vecs[16] = mk(8'h10, 0, 1, 0, 0, 17, 1);
        vecs[17] = mk(8'h11, 0, 1, 0, 0, 18, 0);
        vecs[18] = mk(8'h20, 0, 1, 1, 0, 19, 0);
        vecs[19] = mk(8'h21, 0, 1, 1, 0, 20, 0);
        vecs[20] = mk(8'h22, 0, 1, 1, 0, 21, 0);
        vecs[21] = mk(8'hFD, 0, 1, 2, 0, 22, 0);
        vecs[22] = mk(8'hFE, 0, 1, 2, 0, 23, 1);
        vecs[23] = mk(8'hFF, 0, 1, 2, 0, 24, 0);
        vecs[24] = mk(8'h00, 0, 1, 2, 0, 25, 0);
        vecs[25] = mk(8'h01, 0, 1, 2, 0, 26, 0);
        vecs[26] = mk(8'h02, 1, 1, 2, 1, 27, 0);
        vecs[27] = mk(8'h03, 1, 1, 2, 2, 28, 0);
        vecs[28] = mk(8'h04, 1, 0, 2, 3, 29, 0);
        vecs[29] = mk(8'h55, 1, 0, 2, 4, 30, 0);
        vecs[30] = mk(8'h40, 0, 0, 2, 4, 31, 0);
        vecs[31] = mk(8'h41, 0, 0, 2, 4, 32, 0);
        vecs[32] = mk(8'h42, 0, 0, 2, 4, 33, 0);
        vecs[33] = mk(8'h43, 0, 1, 2, 4, 34, 0);
        vecs[34] = mk(8'h44, 0, 1, 2, 4, 35, 1);
        vecs[35] = mk(8'h90, 0, 1, 3, 4, 36, 0);
        vecs[36] = mk(8'h10, 0, 1, 4, 4, 37, 0);
        vecs[37] = mk(8'h33, 0, 0, 5, 4, 38, 0);

        repeat (3) @(negedge clk);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h3C);
        chk("rst_start_tx", {31'd0, start_tx}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_byte_count", byte_count, 32'd0);
        chk("rst_seq_err", {16'd0, seq_err_count}, 32'd0);
        chk("rst_par_err", {16'd0, par_err_count}, 32'd0);
        chk("rst_tx_timeout", {31'd0, tx_timeout}, 32'd0);
        reset = 1'b0;
        resp_en = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].ack) ack_q.push_back(8'h3C);
            send_byte(vecs[i].d, vecs[i].p);
            chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].l});
            chk($sformatf("v%0d_seq_err", i), {16'd0, seq_err_count}, vecs[i].seq);
            chk($sformatf("v%0d_par_err", i), {16'd0, par_err_count}, vecs[i].par);
            chk($sformatf("v%0d_byte_count", i), byte_count, vecs[i].bc);
        end
        repeat (12) @(negedge clk);
        chk("acks_drained", ack_q.size(), 32'd0);

        // clear_counts in the same cycle as rx_done: the clear wins.
        @(negedge clk);
        rx_data = 8'h70; rx_done = 1'b1; clear_counts = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; clear_counts = 1'b0;
        chk("clr_byte_count", byte_count, 32'd0);
        chk("clr_seq_err", {16'd0, seq_err_count}, 32'd0);
        chk("clr_par_err", {16'd0, par_err_count}, 32'd0);
        chk("clr_locked", {31'd0, locked}, 32'd0);

        // Asynchronous reset while start_tx is held drops it without a clock edge.
        resp_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int b = 0; b < 5; b++) begin
            if (b == 4) ack_q.push_back(8'h3C);
            send_byte(8'(b), 1'b0);
        end
        wait_start();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_async_start", {31'd0, start_tx}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // tx_busy never rises: start_tx held exactly TX_TIMEOUT cycles, then sticky flag.
        for (int b = 0; b < 5; b++) begin
            if (b == 4) ack_q.push_back(8'h3C);
            send_byte(8'(b), 1'b0);
        end
        wait_start();
        cnt = 0;
        while (start_tx === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_start_cycles", cnt, 32'd16);
        chk("to_start_low", {31'd0, start_tx}, 32'd0);
        chk("to_flag_set", {31'd0, tx_timeout}, 32'd1);
        repeat (3) @(negedge clk);
        chk("to_flag_sticky", {31'd0, tx_timeout}, 32'd1);
        chk("to_no_retry", {31'd0, start_tx}, 32'd0);
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        chk("to_flag_cleared", {31'd0, tx_timeout}, 32'd0);
        chk("acks_final", ack_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
